// File: rtl/hyper_bist.sv
// Self-contained memory tester for hyper_xface: writes an address or LFSR pattern
// to a block of dwords, reads it back, and reports mismatches and timeouts.
module hyper_bist #(
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter logic [15:0] TIMEOUT   = 16'd4096,
    parameter logic [31:0] SEED      = 32'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_words,
    output logic        running,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic [31:0] first_err_data,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] addr,
    output logic [31:0] wr_d,
    output logic [3:0]  wr_byte_en,
    output logic [5:0]  rd_num_dwords,
    input  logic        busy,
    input  logic [31:0] rd_d,
    input  logic        rd_rdy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_INIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mode;
    logic [31:0] r_base;
    logic [15:0] r_num;
    logic [15:0] r_idx;
    logic [31:0] r_addr;
    logic [31:0] r_lfsr;
    logic [15:0] r_tcnt;
    logic [1:0]  r_hold;
    logic [15:0] r_err_count;
    logic [31:0] r_first_err_addr;
    logic [31:0] r_first_err_data;
    logic        r_timeout;

    logic        w_accept;
    logic        w_restart;
    logic        w_step;
    logic        w_cmp;
    logic        w_abort;
    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_tmo;
    logic        w_last;
    logic        w_running;
    logic        w_enter_req;
    logic [31:0] w_expect;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_tmo     = (r_tcnt == TIMEOUT);
    assign w_last    = (r_idx == r_num - 16'd1);
    assign w_expect  = r_mode ? r_lfsr : r_addr;
    assign w_running = (r_state != S_IDLE) && (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_restart = 1'b0;
        w_step    = 1'b0;
        w_cmp     = 1'b0;
        w_abort   = 1'b0;
        w_wr_req  = 1'b0;
        w_rd_req  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (num_words == 16'd0) ? S_DONE : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end else if (!busy) begin
                    w_wr_req = 1'b1;
                    w_next   = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                // busy is not trusted until the controller has had 2 cycles to raise it
                if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end else if (r_hold == 2'd0 && !busy) begin
                    w_step = 1'b1;
                    w_next = w_last ? S_RD_INIT : S_WR_REQ;
                end
            end
            S_RD_INIT: begin
                w_restart = 1'b1;
                w_next    = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end else if (!busy) begin
                    w_rd_req = 1'b1;
                    w_next   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end else if (rd_rdy) begin
                    w_cmp  = 1'b1;
                    w_step = 1'b1;
                    w_next = w_last ? S_DONE : S_RD_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_req = ((w_next == S_WR_REQ) || (w_next == S_RD_REQ)) && (w_next != r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode           <= 1'b0;
            r_base           <= 32'd0;
            r_num            <= 16'd0;
            r_idx            <= 16'd0;
            r_addr           <= 32'd0;
            r_lfsr           <= SEED;
            r_tcnt           <= 16'd0;
            r_hold           <= 2'd0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 32'd0;
            r_first_err_data <= 32'd0;
            r_timeout        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode           <= mode;
                r_base           <= base_addr;
                r_num            <= num_words;
                r_idx            <= 16'd0;
                r_addr           <= base_addr;
                r_lfsr           <= SEED;
                r_err_count      <= 16'd0;
                r_first_err_addr <= 32'd0;
                r_first_err_data <= 32'd0;
                r_timeout        <= 1'b0;
            end
            if (w_restart) begin
                r_idx  <= 16'd0;
                r_addr <= r_base;
                r_lfsr <= SEED;
            end
            if (w_step) begin
                r_idx  <= r_idx + 16'd1;
                r_addr <= r_addr + ADDR_STEP;
                r_lfsr <= lfsr_step(r_lfsr);
            end
            if (w_cmp && (rd_d != w_expect)) begin
                r_err_count <= sat_inc(r_err_count);
                if (r_err_count == 16'd0) begin
                    r_first_err_addr <= r_addr;
                    r_first_err_data <= rd_d;
                end
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if (w_enter_req) begin
                r_tcnt <= 16'd0;
            end else if (w_running) begin
                r_tcnt <= r_tcnt + 16'd1;
            end
            if (w_wr_req) begin
                r_hold <= 2'd2;
            end else if (r_state == S_WR_WAIT && r_hold != 2'd0) begin
                r_hold <= r_hold - 2'd1;
            end
        end
    end

    assign running        = w_running;
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err_count == 16'd0) && !r_timeout;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign first_err_data = r_first_err_data;
    assign wr_req         = w_wr_req;
    assign rd_req         = w_rd_req;
    assign addr           = r_addr;
    assign wr_d           = w_expect;
    assign wr_byte_en     = 4'hF;
    assign rd_num_dwords  = 6'h1;

endmodule
